// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
//   Groups the two buses of the memory access unit: the core-side load/store
//   request/response channel and the word-granular RAM data port.
//
//   slave  modport : the mem_access_unit itself
//   master modport : its environment (pipeline plus RAM). The RAM's
//                    combinational read data is driven from this side.
//
//   Request  : req_valid, req_ready, req_write, req_size, req_signed,
//              req_addr, req_wdata
//   Response : rsp_valid, rsp_error, rsp_rdata
//   RAM port : wEn, d_address, d_write_data, d_read_data
// ---------------------------------------------------------------------------
interface mem_access_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_error;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    logic                  wEn;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [DATA_WIDTH-1:0] d_write_data;
    logic [DATA_WIDTH-1:0] d_read_data;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  d_read_data,
        output req_ready, rsp_valid, rsp_error, rsp_rdata,
        output wEn, d_address, d_write_data
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output d_read_data,
        input  req_ready, rsp_valid, rsp_error, rsp_rdata,
        input  wEn, d_address, d_write_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Load/store initiator for a RAM data port with combinational read and
//   posedge write. Byte and halfword loads extract and extend the addressed
//   lane. Byte and halfword stores do read-modify-write on the whole word.
//
//   Ports
//     clock, reset_n : system clock (rising edge), async active-low reset
//     bus (slave)    : request/response channel and RAM data port
//     load_count     : successful loads   (only with MEM_ACCESS_PERF_EN)
//     store_count    : successful stores  (only with MEM_ACCESS_PERF_EN)
//
//   Optional feature macro: MEM_ACCESS_PERF_EN (performance counters).
//
//   Latency from the accept edge (cycle 0): an illegal request responds in
//   cycle 1, a load or word store in cycle 2, a sub-word store in cycle 3.
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    mem_access_unit_if.slave   bus
`ifdef MEM_ACCESS_PERF_EN
    ,
    output logic [31:0]        load_count,
    output logic [31:0]        store_count
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t                state;
    logic                  write_q;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    // Word stores take their data straight from the bus at accept, so only
    // the low halfword is kept for the read-modify-write merge.
    logic [15:0]           wdata_q;

    // Pick the addressed lane(s) out of the RAM word and extend them.
    function automatic logic [DATA_WIDTH-1:0] extract_load(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            size,
        input logic                  sgn,
        input logic [1:0]            lane
    );
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SIZE_BYTE: r = {{24{sgn & b[7]}}, b};
            SIZE_HALF: r = {{16{sgn & h[15]}}, h};
            default:   r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane(s) of the old word with the store data.
    function automatic logic [DATA_WIDTH-1:0] merge_store(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [15:0]           wdata,
        input logic [1:0]            size,
        input logic [1:0]            lane
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_word;
        if (size == SIZE_BYTE) r[{lane, 3'b000} +: 8]    = wdata[7:0];
        else                   r[{lane[1], 4'b0000} +: 16] = wdata;
        return r;
    endfunction

    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lane);
        return (size == 2'b11) ||
               (size == SIZE_HALF && lane[0]) ||
               (size == SIZE_WORD && lane != 2'b00);
    endfunction

    // The captured address drives the RAM directly; the low bits never reach it.
    assign bus.d_address = {addr_q[ADDR_WIDTH-1:2], 2'b00};

`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] load_count_q;
    logic [31:0] store_count_q;
    assign load_count  = load_count_q;
    assign store_count = store_count_q;
`endif

    // NOTE: every output here is a flop cleared asynchronously, so a reset in
    // the middle of WRITE drops wEn immediately and the RAM never commits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            bus.req_ready    <= 1'b1;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_error    <= 1'b0;
            bus.rsp_rdata    <= '0;
            bus.wEn          <= 1'b0;
            bus.d_write_data <= '0;
            write_q          <= 1'b0;
            size_q           <= 2'b00;
            signed_q         <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
`ifdef MEM_ACCESS_PERF_EN
            load_count_q     <= '0;
            store_count_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking default; later assignments in the case win,
            // which makes rsp_valid a single-cycle pulse by construction.
            bus.rsp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    // req_ready is high exactly in IDLE, so req_valid alone accepts.
                    if (bus.req_valid) begin
                        write_q       <= bus.req_write;
                        size_q        <= bus.req_size;
                        signed_q      <= bus.req_signed;
                        addr_q        <= bus.req_addr;
                        wdata_q       <= bus.req_wdata[15:0];
                        bus.req_ready <= 1'b0;
                        bus.rsp_rdata <= '0;
                        if (is_illegal(bus.req_size, bus.req_addr[1:0])) begin
                            bus.rsp_error <= 1'b1;
                            bus.rsp_valid <= 1'b1;
                            state         <= RESP;
                        end else begin
                            bus.rsp_error <= 1'b0;
                            state         <= ACCESS;
                            // A word store writes during ACCESS, so arm it now.
                            if (bus.req_write && bus.req_size == SIZE_WORD) begin
                                bus.wEn          <= 1'b1;
                                bus.d_write_data <= bus.req_wdata;
                            end
                        end
                    end
                end

                ACCESS: begin
                    if (!write_q) begin
                        bus.rsp_rdata <= extract_load(bus.d_read_data, size_q,
                                                      signed_q, addr_q[1:0]);
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else if (size_q == SIZE_WORD) begin
                        bus.wEn       <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        // Old word is on d_read_data now; merge and write next cycle.
                        bus.d_write_data <= merge_store(bus.d_read_data, wdata_q,
                                                        size_q, addr_q[1:0]);
                        bus.wEn          <= 1'b1;
                        state            <= WRITE;
                    end
                end

                WRITE: begin
                    bus.wEn       <= 1'b0;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end

                RESP: begin
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
`ifdef MEM_ACCESS_PERF_EN
                    if (!bus.rsp_error) begin
                        if (write_q) store_count_q <= store_count_q + 32'd1;
                        else         load_count_q  <= load_count_q + 32'd1;
                    end
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//   Directed bench for mem_access_unit with a small behavioural RAM
//   (combinational read, posedge write). Expected values are hand-computed.
//   Define MEM_ACCESS_PERF_EN on both RTL and bench to exercise the counters.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    logic clock;
    logic reset_n;

    mem_access_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] load_count;
    logic [31:0] store_count;
`endif

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef MEM_ACCESS_PERF_EN
        ,
        .load_count  (load_count),
        .store_count (store_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural RAM: 64 words, plus a bench-side preload port.
    logic [31:0] mem [0:63];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;

    assign bus.d_read_data = mem[bus.d_address[7:2]];

    always @(posedge clock) begin
        if (bus.wEn)     mem[bus.d_address[7:2]] <= bus.d_write_data;
        else if (pre_we) mem[pre_idx] <= pre_data;
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; leaves the bench at a negedge.
    task automatic poke(input logic [5:0] idx, input logic [31:0] data);
        pre_we   = 1'b1;
        pre_idx  = idx;
        pre_data = data;
        @(posedge clock);
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    // Issue one request at the current negedge and observe cycles 1..6 at
    // each following negedge until rsp_valid. Returns -1 cycle on timeout.
    task automatic run_req(
        input  logic        w,
        input  logic [1:0]  sz,
        input  logic        sg,
        input  logic [15:0] a,
        input  logic [31:0] wd,
        output int          rsp_cyc,
        output int          wen_cnt,
        output int          wen_cyc,
        output logic [31:0] wen_data,
        output logic [15:0] acc_addr,
        output logic        err,
        output logic [31:0] rdata
    );
        rsp_cyc  = -1;
        wen_cnt  = 0;
        wen_cyc  = -1;
        wen_data = '0;
        acc_addr = '0;
        err      = 1'b0;
        rdata    = '0;
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 6 && rsp_cyc < 0; c++) begin
            if (c == 1) acc_addr = bus.d_address;
            if (bus.wEn) begin
                wen_cnt++;
                wen_cyc  = c;
                wen_data = bus.d_write_data;
            end
            if (bus.rsp_valid) begin
                rsp_cyc = c;
                err     = bus.rsp_error;
                rdata   = bus.rsp_rdata;
            end else begin
                @(negedge clock);
            end
        end
    endtask

    // One cycle after RESP: pulse gone, unit ready again.
    task automatic idle_check(input string tag);
        @(negedge clock);
        check({tag, "_rsp_valid_low"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_req_ready"},     32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    int          rc, wc, wcy, seen;
    logic [31:0] wdat, rd;
    logic [15:0] aa;
    logic        er;

    initial begin
        reset_n        = 1'b0;
        pre_we         = 1'b0;
        pre_idx        = '0;
        pre_data       = '0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        // Reset state
        #12;
        check("rst_req_ready",    32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid",    32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_error",    32'(bus.rsp_error), 32'd0);
        check("rst_rsp_rdata",    bus.rsp_rdata,      32'h0);
        check("rst_wEn",          32'(bus.wEn),       32'd0);
        check("rst_d_address",    32'(bus.d_address), 32'h0);
        check("rst_d_write_data", bus.d_write_data,   32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // 1. Word store then word load
        run_req(1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF, rc, wc, wcy, wdat, aa, er, rd);
        check("sw_rsp_cycle",  32'(rc),  32'd2);
        check("sw_wen_count",  32'(wc),  32'd1);
        check("sw_wen_cycle",  32'(wcy), 32'd1);
        check("sw_wdata",      wdat,     32'hDEADBEEF);
        check("sw_d_address",  32'(aa),  32'h0010);
        check("sw_error",      32'(er),  32'd0);
        idle_check("sw");
        run_req(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, rc, wc, wcy, wdat, aa, er, rd);
        check("lw_rsp_cycle",  32'(rc),  32'd2);
        check("lw_rdata",      rd,       32'hDEADBEEF);
        check("lw_error",      32'(er),  32'd0);
        check("lw_wen_count",  32'(wc),  32'd0);
        idle_check("lw");

        // 2. Byte store read-modify-write
        run_req(1'b1, 2'b00, 1'b0, 16'h0012, 32'h00000055, rc, wc, wcy, wdat, aa, er, rd);
        check("sb_rsp_cycle",  32'(rc),  32'd3);
        check("sb_wen_count",  32'(wc),  32'd1);
        check("sb_wen_cycle",  32'(wcy), 32'd2);
        check("sb_wdata",      wdat,     32'hDE55BEEF);
        check("sb_d_address",  32'(aa),  32'h0010);
        check("sb_rsp_rdata",  rd,       32'h0);
        idle_check("sb");
        check("sb_mem",        mem[4],   32'hDE55BEEF);

        // 3. Signed/unsigned sub-word loads from 0x80FF7F01 at 0x0020
        poke(6'd8, 32'h80FF7F01);
        run_req(1'b0, 2'b00, 1'b1, 16'h0022, 32'h0, rc, wc, wcy, wdat, aa, er, rd);
        check("lb_s_rdata",    rd,       32'hFFFFFFFF);
        check("lb_s_rsp_cycle", 32'(rc), 32'd2);
        idle_check("lb_s");
        run_req(1'b0, 2'b00, 1'b0, 16'h0023, 32'h0, rc, wc, wcy, wdat, aa, er, rd);
        check("lb_u_rdata",    rd,       32'h00000080);
        idle_check("lb_u");
        run_req(1'b0, 2'b01, 1'b1, 16'h0022, 32'h0, rc, wc, wcy, wdat, aa, er, rd);
        check("lh_s_rdata",    rd,       32'hFFFF80FF);
        idle_check("lh_s");
        run_req(1'b0, 2'b01, 1'b0, 16'h0020, 32'h0, rc, wc, wcy, wdat, aa, er, rd);
        check("lh_u_rdata",    rd,       32'h00007F01);
        check("lh_u_error",    32'(er),  32'd0);
        idle_check("lh_u");
        run_req(1'b1, 2'b01, 1'b0, 16'h0022, 32'h1234ABCD, rc, wc, wcy, wdat, aa, er, rd);
        check("sh_wdata",      wdat,     32'hABCD7F01);
        check("sh_rsp_cycle",  32'(rc),  32'd3);
        idle_check("sh");
        check("sh_mem",        mem[8],   32'hABCD7F01);

        // 4. Illegal requests: misaligned half, misaligned word, reserved size
        run_req(1'b1, 2'b01, 1'b0, 16'h0011, 32'hFFFFFFFF, rc, wc, wcy, wdat, aa, er, rd);
        check("mh_rsp_cycle",  32'(rc),  32'd1);
        check("mh_error",      32'(er),  32'd1);
        check("mh_rdata",      rd,       32'h0);
        check("mh_wen_count",  32'(wc),  32'd0);
        idle_check("mh");
        run_req(1'b0, 2'b10, 1'b0, 16'h0012, 32'h0, rc, wc, wcy, wdat, aa, er, rd);
        check("mw_rsp_cycle",  32'(rc),  32'd1);
        check("mw_error",      32'(er),  32'd1);
        check("mw_rdata",      rd,       32'h0);
        idle_check("mw");
        run_req(1'b1, 2'b11, 1'b0, 16'h0010, 32'h12345678, rc, wc, wcy, wdat, aa, er, rd);
        check("rs_rsp_cycle",  32'(rc),  32'd1);
        check("rs_error",      32'(er),  32'd1);
        check("rs_wen_count",  32'(wc),  32'd0);
        idle_check("rs");
        check("err_mem",       mem[4],   32'hDE55BEEF);

        // 5. Reset during WRITE of a byte store
        poke(6'd4, 32'hDEADBEEF);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 16'h0012;
        bus.req_wdata  = 32'h00000077;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        check("rw_access_wEn", 32'(bus.wEn), 32'd0);
        @(negedge clock);
        check("rw_write_wEn",  32'(bus.wEn), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rw_wEn_async",  32'(bus.wEn), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.rsp_valid) seen++;
            @(negedge clock);
        end
        check("rw_no_rsp",     32'(seen),          32'd0);
        check("rw_mem",        mem[4],             32'hDEADBEEF);
        check("rw_req_ready",  32'(bus.req_ready), 32'd1);

`ifdef MEM_ACCESS_PERF_EN
        // 6. Performance counters (cleared by the reset above)
        run_req(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, rc, wc, wcy, wdat, aa, er, rd);
        idle_check("pc_l1");
        run_req(1'b0, 2'b00, 1'b1, 16'h0021, 32'h0, rc, wc, wcy, wdat, aa, er, rd);
        idle_check("pc_l2");
        run_req(1'b1, 2'b10, 1'b0, 16'h0030, 32'h01020304, rc, wc, wcy, wdat, aa, er, rd);
        idle_check("pc_s1");
        run_req(1'b0, 2'b01, 1'b0, 16'h0022, 32'h0, rc, wc, wcy, wdat, aa, er, rd);
        idle_check("pc_l3");
        run_req(1'b1, 2'b00, 1'b0, 16'h0033, 32'h000000AA, rc, wc, wcy, wdat, aa, er, rd);
        idle_check("pc_s2");
        run_req(1'b0, 2'b10, 1'b0, 16'h0031, 32'h0, rc, wc, wcy, wdat, aa, er, rd);
        idle_check("pc_err");
        check("pc_load_count",  load_count,  32'd3);
        check("pc_store_count", store_count, 32'd2);
        force dut.store_count_q = 32'hFFFFFFFF;
        @(negedge clock);
        release dut.store_count_q;
        run_req(1'b1, 2'b10, 1'b0, 16'h0030, 32'h0, rc, wc, wcy, wdat, aa, er, rd);
        idle_check("pc_wrap");
        check("pc_store_wrap",  store_count, 32'd0);
        check("pc_load_hold",   load_count,  32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
